// File: rtl/yuv_chroma_upsampler.sv
// Reads planar Y and 2:1 horizontally subsampled U/V from SRAM and writes
// {Y,Y} {U,Uodd} {V,Vodd} triplets per pixel pair, interpolating odd chroma.
module yuv_chroma_upsampler #(
    parameter int unsigned ADDR_OUT = 0,
    parameter int unsigned ADDR_Y   = 115200,
    parameter int unsigned ADDR_U   = 153600,
    parameter int unsigned ADDR_V   = 172800,
    parameter int unsigned W        = 320,
    parameter int unsigned H        = 240,
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          wr_enable
);

    localparam int unsigned SW     = DW / 2;
    localparam int unsigned GROUPS = W / 4;
    localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned RW     = (H > 1) ? $clog2(H) : 1;

    typedef enum logic [1:0] {StIdle, StLead, StGroup, StFlush} state_e;

    state_e        state_q, state_d;
    logic [2:0]    phase_q, phase_d;
    logic [GW-1:0] grp_q, grp_d;
    logic [RW-1:0] row_q, row_d;
    logic          done_d;
    logic          last_grp, last_row, last_grp_d, in_grp;
    logic          rd_y, rd_u, rd_v;
    logic [AW-1:0] y_ptr_q, u_ptr_q, v_ptr_q, y_ptr_d, u_ptr_d, v_ptr_d;
    logic [AW-1:0] y_base, u_base, v_base, raddr_d, w_ptr;
    logic [DW-1:0] u_a, u_b, v_a, v_b, y_hold, wdata_d;
    logic          pend_v, pend_last, wr_d;

    function automatic logic [SW-1:0] avg(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW:0] s;
        s = {1'b0, a} + {1'b0, b} + (SW+1)'(1);
        return s[SW:1];
    endfunction

    assign last_grp   = (grp_q == GW'(GROUPS - 1));
    assign last_row   = (row_q == RW'(H - 1));
    assign last_grp_d = (grp_d == GW'(GROUPS - 1));
    assign in_grp     = (state_q == StGroup);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        grp_d   = grp_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLead;
                    phase_d = '0;
                    grp_d   = '0;
                    row_d   = '0;
                end
            end
            StLead: begin
                if (phase_q == 3'd1) begin
                    state_d = StGroup;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            StGroup: begin
                if (phase_q == 3'd5) begin
                    phase_d = '0;
                    if (!last_grp) begin
                        grp_d = grp_q + 1'b1;
                    end else begin
                        grp_d = '0;
                        if (last_row) begin
                            state_d = StFlush;
                        end else begin
                            state_d = StLead;
                            row_d   = row_q + 1'b1;
                        end
                    end
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            default: begin
                if (phase_q == 3'd1) begin
                    state_d = StIdle;
                    phase_d = '0;
                    done_d  = 1'b1;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
        endcase
    end

    // raddr is registered, so the read issued in a cycle is decoded from the next state.
    always_comb begin
        rd_y    = (state_d == StGroup) && (phase_d < 3'd2);
        rd_u    = ((state_d == StLead) && (phase_d == 3'd0)) ||
                  ((state_d == StGroup) && (phase_d == 3'd2) && !last_grp_d);
        rd_v    = ((state_d == StLead) && (phase_d == 3'd1)) ||
                  ((state_d == StGroup) && (phase_d == 3'd3) && !last_grp_d);
        y_base  = (state_q == StIdle) ? AW'(ADDR_Y) : y_ptr_q;
        u_base  = (state_q == StIdle) ? AW'(ADDR_U) : u_ptr_q;
        v_base  = (state_q == StIdle) ? AW'(ADDR_V) : v_ptr_q;
        raddr_d = raddr;
        y_ptr_d = y_base;
        u_ptr_d = u_base;
        v_ptr_d = v_base;
        if (rd_y) begin
            raddr_d = y_base;
            y_ptr_d = y_base + AW'(1);
        end else if (rd_u) begin
            raddr_d = u_base;
            u_ptr_d = u_base + AW'(1);
        end else if (rd_v) begin
            raddr_d = v_base;
            v_ptr_d = v_base + AW'(1);
        end
    end

    // Output word for the next cycle; the pair-1 V word spills into the following state.
    always_comb begin
        wr_d    = 1'b0;
        wdata_d = '0;
        if (pend_v) begin
            wr_d    = 1'b1;
            wdata_d = {v_a[SW-1:0], avg(v_a[SW-1:0], pend_last ? v_a[SW-1:0] : v_b[DW-1:SW])};
        end else if (in_grp) begin
            case (phase_q)
                3'd1: begin
                    wr_d    = 1'b1;
                    wdata_d = rdata;
                end
                3'd2: begin
                    wr_d    = 1'b1;
                    wdata_d = {u_a[DW-1:SW], avg(u_a[DW-1:SW], u_a[SW-1:0])};
                end
                3'd3: begin
                    wr_d    = 1'b1;
                    wdata_d = {v_a[DW-1:SW], avg(v_a[DW-1:SW], v_a[SW-1:0])};
                end
                3'd4: begin
                    wr_d    = 1'b1;
                    wdata_d = y_hold;
                end
                3'd5: begin
                    wr_d    = 1'b1;
                    wdata_d = {u_a[SW-1:0],
                               avg(u_a[SW-1:0], last_grp ? u_a[SW-1:0] : u_b[DW-1:SW])};
                end
                default: begin
                    wr_d    = 1'b0;
                    wdata_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            phase_q <= '0;
            grp_q   <= '0;
            row_q   <= '0;
            raddr   <= '0;
            y_ptr_q <= '0;
            u_ptr_q <= '0;
            v_ptr_q <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            grp_q   <= grp_d;
            row_q   <= row_d;
            raddr   <= raddr_d;
            y_ptr_q <= y_ptr_d;
            u_ptr_q <= u_ptr_d;
            v_ptr_q <= v_ptr_d;
            done    <= done_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_a       <= '0;
            u_b       <= '0;
            v_a       <= '0;
            v_b       <= '0;
            y_hold    <= '0;
            pend_v    <= 1'b0;
            pend_last <= 1'b0;
            w_ptr     <= '0;
            waddr     <= '0;
            wdata     <= '0;
            wr_enable <= 1'b0;
        end else begin
            wr_enable <= wr_d;
            pend_v    <= in_grp && (phase_q == 3'd5);
            if (in_grp && (phase_q == 3'd5)) pend_last <= last_grp;
            if (wr_d) begin
                waddr <= w_ptr;
                wdata <= wdata_d;
                w_ptr <= w_ptr + AW'(1);
            end else if (state_q == StIdle) begin
                w_ptr <= AW'(ADDR_OUT);
            end
            if ((state_q == StLead) && (phase_q == 3'd1)) u_a <= rdata;
            else if (in_grp && (phase_q == 3'd5) && !last_grp) u_a <= u_b;
            if (in_grp && (phase_q == 3'd0) && (grp_q == '0)) v_a <= rdata;
            else if (pend_v && !pend_last) v_a <= v_b;
            if (in_grp && (phase_q == 3'd2)) y_hold <= rdata;
            if (in_grp && (phase_q == 3'd3) && !last_grp) u_b <= rdata;
            if (in_grp && (phase_q == 3'd4) && !last_grp) v_b <= rdata;
        end
    end

endmodule

// File: doc/yuv_chroma_upsampler.md
# yuv_chroma_upsampler

Stage directly upstream of the YUV-to-RGB colour conversion. It reads planar Y and horizontally 2:1-subsampled U/V from SRAM and interpolates chroma to full horizontal resolution. It writes pixel-pair triplets {Y, U, V} into the region the converter reads. It owns the SRAM read and write ports for the duration of one frame, then pulses `done`.

## Interface
- ADDR_OUT, 0: base of output triplet region (converter input)
- ADDR_Y, 115200: base of packed Y plane (W*H/2 words)
- ADDR_U, 153600: base of packed U plane (W*H/4 words)
- ADDR_V, 172800: base of packed V plane (W*H/4 words)
- W, 320: frame width in pixels; must be a multiple of 4
- H, 240: frame height in rows
- DW, 16: SRAM data width
- AW, 18: SRAM address width

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  begin one frame; sampled only in IDLE
- done  out  1  one-cycle pulse after the last write of the frame
- raddr  out  AW  SRAM read address; data returns on `rdata` the next cycle
- rdata  in  DW  SRAM read data
- waddr  out  AW  SRAM write address
- wdata  out  DW  SRAM write data
- wr_enable  out  1  write strobe; waddr/wdata are valid the same cycle

## Operation
- Packing: every input word is {even sample [15:8], odd sample [7:0]}. Y word k holds pixels 2k and 2k+1. U/V word k of a row holds chroma samples 2k and 2k+1; chroma sample j is co-sited with pixel 2j.
- For pixel pair p (pixels 2j, 2j+1 of a row), the block writes three words at ADDR_OUT+3p, +1, +2:
  - {Y[2j], Y[2j+1]}
  - {U[j], Uodd}
  - {V[j], Vodd}
- Uodd = (U[j]+U[j+1]+1)>>1, computed with a 9-bit sum, result 8 bits. Vodd uses the same rule.
- Row-end clamp: for the last pair of a row, U[j+1] is replaced by U[W/2-1]; V is clamped the same way. Chroma is never interpolated across rows.
- p runs 0 .. W*H/2-1 in raster order, so the output region spans 3*W*H/2 words.
- FSM states:
  - IDLE: on start=1, go to LEAD.
  - LEAD: 2 cycles. Read the first U word, then the first V word, of the current row. Go to GROUP.
  - GROUP: 6 cycles per 4-pixel group, W/4 groups per row.
  - Row boundary: after the last group, go to LEAD for the next row. After the last group of row H-1, go to FLUSH.
  - FLUSH: wait for the last pending writes, pulse done, go to IDLE.
- GROUP cycles G0..G5:
  - Reads: Y word 2g at G0, Y word 2g+1 at G1, next U word at G2, next V word at G3.
  - The next-U/V reads are suppressed on the last group of a row (raddr holds its value; no new data is used).
  - G4 and G5 issue no reads.
- Writes for group g occupy cycles G2..G7, one per cycle, in address order: pair 0 Y/U/V, then pair 1 Y/U/V. G6 and G7 overlap the following state.
- Consecutive groups produce back-to-back writes. wr_enable is low only between rows and outside a frame.
- `start` asserted outside IDLE is ignored.

## Timing
- Reset values: raddr=0, waddr=0, wdata=0, wr_enable=0, done=0; FSM in IDLE.
- Reset asserted mid-frame: wr_enable drops asynchronously. No further writes occur. The block needs a new start after reset is released.
- Row time R = 2 + 6*(W/4) cycles (482 for W=320).
- Frame timing, counting the cycle start is sampled as cycle 0:
  - LEAD of row 0 begins at cycle 1.
  - The final write occurs at cycle H*R+2.
  - done is high for exactly one cycle, at cycle H*R+3 (115683 for defaults).
- First write (pair 0 Y word) occurs at cycle 5.
- Read-to-use: rdata sampled exactly one cycle after raddr was driven; no other latency is tolerated.

## Test plan
- W=8, H=2, Y word k = k, U row0 = {10,20},{30,40}, V = U+100; start at cycle 0 -> first write at cycle 5: addr 0, data 0x0000; done pulse at cycle 31; exactly 24 writes.
- Interpolation rounding: U[j]=0x01, U[j+1]=0x02 -> Uodd=0x02; U=0xFF,0xFF -> 0xFF (no overflow); U=0x00,0xFF -> 0x80.
- Row-end clamp: last pair of a row with U[W/2-1]=0x40 and next-row U[0]=0xC0 -> Uodd=0x40. Next row's first even U is 0xC0.
- Reset (low) asserted at cycle 12 of a W=8,H=2 frame -> wr_enable=0 and all outputs at reset values immediately. No done pulse. A new start gives the full cycle-31 done timing and correct data.
- start pulsed again at cycle 10 mid-frame -> ignored; write count and done timing unchanged.
- Default parameters, random planes, compared against a reference model -> 115200 writes, addresses 0..115199 each written once, done at cycle 115683.
